sram_burst_ctrl: RTL and testbench
==================================

// Module: sram_burst_ctrl
// PURPOSE
//  Burst memory controller sitting directly upstream of the dual-port sram; drives port A only.
//  Accepts one burst command (read or write, base address, length) over a valid/ready handshake.
//  Streams write beats into the sram and read beats out to a consumer with full backpressure.
//  Hides the sram's 1-cycle read latency behind a 2-entry read buffer.
// PARAMETERS
//  DATA_WIDTH  32  width of a data word (matches sram DATA_WIDTH)
//  ADDR_WIDTH  16  word address width (matches sram ADDR_WIDTH)
//  LEN_WIDTH   8   burst length field width; burst = cmd_len+1 beats (1..2**LEN_WIDTH)
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  rst        in   1           synchronous active-high reset
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           controller can accept a command (high only in IDLE)
//  cmd_write  in   1           1 = write burst, 0 = read burst
//  cmd_addr   in   ADDR_WIDTH  burst base word address
//  cmd_len    in   LEN_WIDTH   beats minus one
//  wr_valid   in   1           write beat present
//  wr_ready   out  1           write beat accepted this cycle when wr_valid also high
//  wr_data    in   DATA_WIDTH  write beat data
//  rd_valid   out  1           read beat present
//  rd_ready   in   1           consumer takes read beat
//  rd_data    out  DATA_WIDTH  read beat data
//  rd_last    out  1           qualifies final beat of a read burst
//  busy       out  1           high in any state other than IDLE
//  mem_addr   out  ADDR_WIDTH  to sram addr_a
//  mem_data   out  DATA_WIDTH  to sram data_a
//  mem_we     out  1           to sram we_a
//  mem_q      in   DATA_WIDTH  from sram q_a (valid 1 cycle after mem_addr presented)
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1, wr_ready=0, rd_valid=0, rd_last=0, busy=0, mem_we=0,
//   mem_addr=0, read buffer and in-flight tracking cleared. rd_data and mem_data are don't-care.
//  FSM: IDLE -> WRITE (accepted cmd, cmd_write=1) | READ (accepted cmd, cmd_write=0);
//   WRITE -> IDLE after last beat; READ -> DRAIN after last address issued;
//   DRAIN -> IDLE once buffer empty and nothing in flight.
//  Command accept: cmd_valid && cmd_ready at posedge latches addr/len/dir; cmd_ready=0 otherwise.
//  WRITE: wr_ready=1; on a beat (wr_valid && wr_ready), mem_we=1, mem_addr=cur, mem_data=wr_data
//   combinationally in the same cycle, so the sram writes at that posedge. cur increments after each beat.
//   Cycles without wr_valid: mem_we=0.
//  READ: issue address cur (mem_we=0) when buffer_count + inflight - pop < 2
//   (pop = rd_valid && rd_ready); captured mem_q enters buffer next posedge.
//  Latency: command accepted at edge T -> first mem_addr in cycle T+1 -> rd_valid in cycle T+3.
//   With rd_ready held high, one beat per cycle thereafter.
//  rd_data/rd_last stable while rd_valid && !rd_ready; no beat dropped or duplicated.
//  Address wrap: cur increments modulo 2**ADDR_WIDTH (0xFFFF -> 0x0000 at default width).
//  mem_we is never asserted outside WRITE; port B of the sram is not driven by this block.
//  Reset mid-burst: burst abandoned, buffered beats discarded, no further mem_we; sram content
//   already written is kept.
//  cmd_valid while busy is ignored; command held by master until cmd_ready.
// TESTING
//  Write addr 0x0010 len 3 data A,B,C,D; read back same -> rd_data A,B,C,D, rd_last on 4th only, mem_we high exactly 4 cycles.
//  Write addr 0xFFFE len 3 -> sram words 0xFFFE,0xFFFF,0x0000,0x0001 hold beats 0..3; read burst returns same order.
//  Read len 15, rd_ready=1 -> rd_valid at T+3, then 16 beats in 16 consecutive cycles, busy drops after last beat.
//  Read len 7, rd_ready toggling 1,0,1,0 -> 8 beats in order, data stable during stalls, never >2 buffered.
//  Write len 4 with wr_valid gaps (1,0,0,1,1,0,1,1) -> mem_we only on beat cycles, 5 consecutive addresses written.
//  rst pulse after 3 read beats -> next cycle rd_valid=0, busy=0, cmd_ready=1; cmd_valid high during busy never accepted.

Source files
------------

// File: rtl/sram_burst_ctrl.sv
// ============================================================================
//  Module      : sram_burst_ctrl
//  Description : Burst read/write controller for port A of a 1-cycle-latency
//                sram, with a 2-entry read buffer for full-rate backpressure.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module sram_burst_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic                  r_buf_last [2];
  logic                  r_rptr;
  logic                  r_wptr;
  logic [1:0]            r_count;

  logic w_pop;
  logic w_issue;
  logic w_beat;
  logic w_last_addr;

  assign w_pop       = rd_valid && rd_ready;
  assign w_last_addr = (r_remain == '0);

  assign mem_addr = r_cur;
  assign mem_data = wr_data;
  assign rd_valid = (r_count != 2'd0);
  assign rd_data  = r_buf_data[r_rptr];
  assign rd_last  = rd_valid && r_buf_last[r_rptr];
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    mem_we      = 1'b0;
    w_issue     = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = cmd_write ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        w_beat   = wr_valid;
        mem_we   = wr_valid;
        if (wr_valid && w_last_addr) w_state_nxt = S_IDLE;
      end
      S_READ: begin
        // Issue only if the beat returning next cycle is guaranteed a buffer slot.
        w_issue = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
        if (w_issue && w_last_addr) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_inflight && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur           <= '0;
      r_remain        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_rptr          <= 1'b0;
      r_wptr          <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        r_cur    <= cmd_addr;
        r_remain <= cmd_len;
      end else if (w_beat || w_issue) begin
        r_cur    <= r_cur + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_last_addr;
      if (r_inflight) r_wptr <= ~r_wptr;
      if (w_pop)      r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // Buffer storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_buf_data[r_wptr] <= mem_q;
      r_buf_last[r_wptr] <= r_inflight_last;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
// ============================================================================
//  Module      : tb_sram_burst_ctrl
//  Description : Directed, table-driven bench for sram_burst_ctrl with an
//                sram port-A model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sram_burst_ctrl;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready, rd_last, busy;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_we;

  always #5 clk = ~clk;

  sram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
  );

  // sram port A: write at the edge, registered read data one cycle later
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_data;
    mem_q <= sram[mem_addr];
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [7:0]    pat;   // wr_valid / rd_ready pattern, bit (cycle % 8)
    logic [DW-1:0] base;  // beat i carries base + i
    int            done;  // expected cycle index of the final read beat, 0 = unchecked
  } vec_t;

  vec_t tbl [9];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input vec_t v);
    int            beats, cyc, we_cnt;
    logic [AW-1:0] a;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = v.addr; cmd_len = v.len;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    beats = 0; cyc = 0; we_cnt = 0;
    while (beats <= int'(v.len) && cyc < 200) begin
      wr_valid = v.pat[cyc % 8];
      wr_data  = v.base + DW'(beats);
      #1;
      if (mem_we) we_cnt++;
      if (wr_valid && wr_ready) begin
        a = v.addr + AW'(beats);
        chk("wr_beat_we", mem_we, 1);
        chk("wr_beat_addr", mem_addr, a);
        beats++;
      end else begin
        chk("wr_gap_we", mem_we, 0);
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0;
    chk("wr_beats_done", beats, v.len + 1);
    chk("wr_we_count", we_cnt, v.len + 1);
    #1 chk("wr_busy_after", busy, 0);
    for (int i = 0; i <= int'(v.len); i++) begin
      a = v.addr + AW'(i);
      chk("sram_word", sram[a], v.base + DW'(i));
    end
  endtask

  task automatic do_read(input vec_t v, input int stop_after);
    int            beats, k, last_k;
    logic          held, prev_last;
    logic [DW-1:0] prev_data;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = v.addr; cmd_len = v.len;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    // keep offering a different command while busy; it must never be taken
    cmd_write = 1'b1; cmd_addr = 16'hDEAD;
    beats = 0; k = 1; last_k = 0; held = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (beats <= int'(v.len) && k < 300 && beats != stop_after) begin
      rd_ready = v.pat[k % 8];
      #1;
      chk("cmd_ready_busy", cmd_ready, 0);
      chk("rd_no_we", mem_we, 0);
      if (k < 3)  chk("rd_latency_early", rd_valid, 0);
      if (k == 3) chk("rd_latency_first", rd_valid, 1);
      if (held) begin
        chk("stall_data", rd_data, prev_data);
        chk("stall_last", rd_last, prev_last);
      end
      if (rd_valid && rd_ready) begin
        chk("rd_data", rd_data, v.base + DW'(beats));
        chk("rd_last", rd_last, beats == int'(v.len));
        last_k = k;
        beats++;
      end
      held = rd_valid && !rd_ready;
      prev_data = rd_data;
      prev_last = rd_last;
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0; rd_ready = 1'b0;
    if (stop_after < 0) begin
      chk("rd_beats_done", beats, v.len + 1);
      #1 chk("rd_busy_after", busy, 0);
      if (v.done != 0) chk("rd_last_cycle", last_k, v.done);
    end else begin
      chk("rd_beats_before_rst", beats, stop_after);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h0010, 8'd3,  8'hFF,        32'hA0A0_0000, 0};
    tbl[1] = '{1'b0, 16'h0010, 8'd3,  8'hFF,        32'hA0A0_0000, 6};
    tbl[2] = '{1'b1, 16'hFFFE, 8'd3,  8'hFF,        32'h0000_0100, 0};
    tbl[3] = '{1'b0, 16'hFFFE, 8'd3,  8'hFF,        32'h0000_0100, 6};
    tbl[4] = '{1'b1, 16'h0200, 8'd15, 8'hFF,        32'h0000_0200, 0};
    tbl[5] = '{1'b0, 16'h0200, 8'd15, 8'hFF,        32'h0000_0200, 18};
    tbl[6] = '{1'b0, 16'h0200, 8'd7,  8'h55,        32'h0000_0200, 0};
    tbl[7] = '{1'b1, 16'h0300, 8'd4,  8'b1101_1001, 32'h0000_0300, 0};
    tbl[8] = '{1'b0, 16'h0300, 8'd4,  8'hFF,        32'h0000_0300, 7};

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].wr) do_write(tbl[i]);
      else           do_read(tbl[i], -1);
    end

    // reset in the middle of a read burst after three beats
    do_read('{1'b0, 16'h0200, 8'd7, 8'hFF, 32'h0000_0200, 0}, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_mem_we", mem_we, 0);

    // controller recovers and earlier sram content survives the reset
    do_read(tbl[1], -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
